// File: rtl/lottery_draw.sv
`default_nettype none
// ============================================================================
//  Module   : lottery_draw
//  Purpose  : Bit-serial lottery. Enrols up to 32 participants (one lucky bit
//             each) and, on stop, scans the queue from a pseudo-random start
//             index for the first lucky participant.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk      in   1  rising-edge clock
//    reset    in   1  asynchronous, active-low reset
//    luckybit in   1  lucky bit of the participant being enrolled
//    write    in   1  enrol strobe (one participant per high cycle)
//    stop     in   1  close enrolment and start the draw
//    winner   out  5  id of the drawn participant (0 if nobody was lucky)
//    id       out  5  id of the most recently enrolled participant
//    full     out  1  all 32 entries filled
// ============================================================================
module lottery_draw (
  input  logic       clk,
  input  logic       reset,
  input  logic       luckybit,
  input  logic       write,
  input  logic       stop,
  output logic [4:0] winner,
  output logic [4:0] id,
  output logic       full
);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    DRAW    = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [31:0] queue;
  logic [5:0]  count;
  logic [4:0]  lfsr;
  logic [4:0]  ptr;
  logic [5:0]  scans;

  logic        start_draw;
  logic        enrol;
  logic        hit;
  logic        exhausted;

  always_comb begin
    start_draw = 1'b0;
    enrol      = 1'b0;
    hit        = 1'b0;
    exhausted  = 1'b0;
    state_next = state;

    // stop takes priority over a write presented in the same cycle
    start_draw = (state == COLLECT) && stop && (count != 6'd0);
    enrol      = (state == COLLECT) && !start_draw && write && !count[5];

    // Entries at or beyond count were never enrolled and cannot win
    hit        = (state == DRAW) && ({1'b0, ptr} < count) && queue[ptr];
    // Last of the 32 probes missed: report winner 0
    exhausted  = (state == DRAW) && !hit && (scans == 6'd31);

    case (state)
      COLLECT: if (start_draw)       state_next = DRAW;
      DRAW:    if (hit || exhausted) state_next = DONE;
      DONE:                          state_next = DONE;
      default:                       state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      queue  <= 32'd0;
      count  <= 6'd0;
      lfsr   <= 5'b00001;
      ptr    <= 5'd0;
      scans  <= 6'd0;
      winner <= 5'd0;
      id     <= 5'd0;
      full   <= 1'b0;
    end else begin
      // x^5+x^3+1 Fibonacci LFSR, free-running in every state
      lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};

      if (enrol) begin
        queue[count[4:0]] <= luckybit;
        id                <= count[4:0];
        count             <= count + 6'd1;
        if (count == 6'd31) begin
          full <= 1'b1;
        end
      end

      if (start_draw) begin
        ptr   <= lfsr;
        scans <= 6'd0;
      end

      if (state == DRAW) begin
        if (hit) begin
          winner <= ptr;
        end else begin
          ptr   <= ptr + 5'd1;
          scans <= scans + 6'd1;
          if (exhausted) begin
            winner <= 5'd0;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lottery_draw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lottery_draw
//  Purpose  : Self-checking bench for lottery_draw. A reference model of the
//             enrolment queue and LFSR predicts id/full/winner; expectations
//             are queued when stimulus is driven and compared when the DUT
//             output becomes visible.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lottery_draw;

  logic       clk;
  logic       reset;
  logic       luckybit;
  logic       write;
  logic       stop;
  logic [4:0] winner;
  logic [4:0] id;
  logic       full;

  lottery_draw dut (
    .clk      (clk),
    .reset    (reset),
    .luckybit (luckybit),
    .write    (write),
    .stop     (stop),
    .winner   (winner),
    .id       (id),
    .full     (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  logic [4:0]  m_lfsr;
  logic [31:0] m_queue;
  int          m_count;
  logic [4:0]  m_id;
  logic        m_full;

  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 5'b00001;
    else        m_lfsr <= {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
  end

  localparam int c_SEL_ID     = 0;
  localparam int c_SEL_FULL   = 1;
  localparam int c_SEL_WINNER = 2;

  typedef struct {
    int         sel;
    logic [4:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];

  int total;
  int bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int sel, input logic [4:0] val, input string tag);
    exp_t e;
    e.sel = sel;
    e.val = val;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t       e;
    logic [4:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        c_SEL_ID:   obs = id;
        c_SEL_FULL: obs = {4'd0, full};
        default:    obs = winner;
      endcase
      check(e.tag, {27'd0, obs}, {27'd0, e.val});
    end
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    write    = 1'b0;
    stop     = 1'b0;
    luckybit = 1'b0;
    m_queue  = 32'd0;
    m_count  = 0;
    m_id     = 5'd0;
    m_full   = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // One write cycle; the model ignores it when full or outside collection
  task automatic do_write(input logic b, input bit collecting, input string tag);
    write    = 1'b1;
    luckybit = b;
    if (collecting && m_count < 32) begin
      m_queue[m_count] = b;
      m_id             = m_count[4:0];
      m_count++;
      if (m_count == 32) m_full = 1'b1;
    end
    push(c_SEL_ID, m_id, {tag, ".id"});
    push(c_SEL_FULL, {4'd0, m_full}, {tag, ".full"});
    tick();
    write = 1'b0;
    drain();
  endtask

  // Drive stop, predict winner and latency from the model LFSR, then check
  task automatic do_draw(input string tag);
    logic [4:0] start;
    logic [4:0] p;
    logic [4:0] exp_win;
    int         lat;
    bit         found;
    start   = m_lfsr;
    exp_win = 5'd0;
    lat     = 33;
    found   = 1'b0;
    for (int k = 0; k < 32; k++) begin
      p = start + k[4:0];
      if (!found && int'(p) < m_count && m_queue[p]) begin
        found   = 1'b1;
        exp_win = p;
        lat     = k + 2;
      end
    end
    stop = 1'b1;
    push(c_SEL_WINNER, exp_win, {tag, ".winner"});
    tick();
    stop = 1'b0;
    for (int i = 0; i < lat - 2; i++) tick();
    check({tag, ".pre"}, {27'd0, winner}, 32'd0);
    tick();
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // ---- reset state
    do_reset();
    check("rst.winner", {27'd0, winner}, 32'd0);
    check("rst.id", {27'd0, id}, 32'd0);
    check("rst.full", {31'd0, full}, 32'd0);
    check("rst.lfsr", {27'd0, dut.lfsr}, 32'd1);

    // ---- enrol 1,0,1
    do_write(1'b1, 1'b1, "w0");
    do_write(1'b0, 1'b1, "w1");
    do_write(1'b1, 1'b1, "w2");
    check("q101", {29'd0, dut.queue[2:0]}, 32'd5);

    // ---- 36 random writes, overflow ignored, then draw
    do_reset();
    for (int i = 0; i < 36; i++) do_write(1'($urandom_range(0, 1)), 1'b1, $sformatf("fill%0d", i));
    check("fill.queue", dut.queue, m_queue);
    do_draw("rnd");

    // ---- reset asserted mid-draw clears asynchronously
    do_reset();
    for (int i = 0; i < 32; i++) do_write(1'($urandom_range(0, 1)), 1'b1, $sformatf("f2_%0d", i));
    stop = 1'b1;
    tick();
    stop = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("arst.id", {27'd0, id}, 32'd0);
    check("arst.full", {31'd0, full}, 32'd0);
    check("arst.winner", {27'd0, winner}, 32'd0);
    check("arst.lfsr", {27'd0, dut.lfsr}, 32'd1);
    do_reset();
    do_write(1'b1, 1'b1, "fresh");
    do_draw("fresh");

    // ---- 8 entries, only entry 5 lucky
    do_reset();
    for (int i = 0; i < 8; i++) do_write(i == 5, 1'b1, $sformatf("e%0d", i));
    do_draw("lucky5");
    do_write(1'b1, 1'b0, "done.w");
    stop = 1'b1;
    tick();
    stop = 1'b0;
    push(c_SEL_WINNER, 5'd5, "done.hold");
    drain();
    // async clear of a nonzero winner
    #2;
    reset = 1'b0;
    #1;
    check("arst2.winner", {27'd0, winner}, 32'd0);

    // ---- 4 unlucky entries: full 33-cycle scan, winner 0, then terminal
    do_reset();
    for (int i = 0; i < 4; i++) do_write(1'b0, 1'b1, $sformatf("z%0d", i));
    do_draw("nolucky");
    do_write(1'b1, 1'b0, "nolucky.w");

    // ---- stop with no entries is ignored
    do_reset();
    stop = 1'b1;
    tick();
    tick();
    stop = 1'b0;
    push(c_SEL_WINNER, 5'd0, "empty.winner");
    drain();
    do_write(1'b0, 1'b1, "empty.w0");
    do_write(1'b1, 1'b1, "empty.w1");
    // stop and write together: stop wins, no enrolment
    stop     = 1'b1;
    write    = 1'b1;
    luckybit = 1'b1;
    tick();
    stop  = 1'b0;
    write = 1'b0;
    check("sw.id", {27'd0, id}, 32'd1);
    check("sw.queue", {30'd0, dut.queue[2], dut.queue[1]}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
